// File: rtl/goertzel_pkg.sv
// Shared constants, FSM state type and saturating add for the Goertzel recurrence.
// sat_add is only referenced when GOERTZEL_SAT_EN is defined.
package goertzel_pkg;

  localparam int N    = 61;
  localparam int FRAC = 30;

  localparam logic [N-1:0] Q30_ONE = {{(N-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_X = 2'd1,
    ST_ACC    = 2'd2
  } state_e;

  // a + b - c evaluated with two guard bits, then clamped to the signed N-bit range
  function automatic logic [N-1:0] sat_add(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic [N-1:0] c);
    logic signed [N+1:0] w;
    logic signed [N+1:0] max_v;
    logic signed [N+1:0] min_v;
    max_v = {3'b000, {(N-1){1'b1}}};
    min_v = {3'b111, {(N-1){1'b0}}};
    w = $signed({{2{a[N-1]}}, a}) + $signed({{2{b[N-1]}}, b}) - $signed({{2{c[N-1]}}, c});
    if (w > max_v) begin
      sat_add = max_v[N-1:0];
    end else if (w < min_v) begin
      sat_add = min_v[N-1:0];
    end else begin
      sat_add = w[N-1:0];
    end
  endfunction

endpackage

// File: rtl/goertzel_recurrence_if.sv
// Sample/multiplier/result bundle for goertzel_recurrence; slave = recurrence side.
interface goertzel_recurrence_if;
  import goertzel_pkg::*;

  logic         start;
  logic [N-1:0] coeff;
  logic         x_valid;
  logic         x_ready;
  logic [N-1:0] x_data;
  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  logic         mul_en;
  logic [N-1:0] mul_y;
  logic         busy;
  logic         done;
  logic [N-1:0] s1_out;
  logic [N-1:0] s2_out;

  modport slave (
    input  start, coeff, x_valid, x_data, mul_y,
    output x_ready, mul_a, mul_b, mul_en, busy, done, s1_out, s2_out
  );

  modport master (
    output start, coeff, x_valid, x_data, mul_y,
    input  x_ready, mul_a, mul_b, mul_en, busy, done, s1_out, s2_out
  );

endinterface

// File: rtl/goertzel_sample_counter.sv
// Per-block sample counter; flags the final sample of a BLOCK_LEN block.
module goertzel_sample_counter #(
  parameter int BLOCK_LEN = 205,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == LAST_IDX);

endmodule

// File: rtl/goertzel_recurrence.sv
// Goertzel recurrence s[n] = x[n] + coeff*s[n-1] - s[n-2] around an external 1-cycle Q30 multiplier.
// Define GOERTZEL_SAT_EN to saturate s[n] instead of wrapping it.
module goertzel_recurrence
  import goertzel_pkg::*;
#(
  parameter int BLOCK_LEN = 205,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  goertzel_recurrence_if.slave  bus
);

  state_e       state_q, state_d;
  logic [N-1:0] coeff_q, coeff_d;
  logic [N-1:0] s1_q, s1_d;
  logic [N-1:0] s2_q, s2_d;
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] s1_out_q, s1_out_d;
  logic [N-1:0] s2_out_q, s2_out_d;
  logic         done_q, done_d;
  logic [N-1:0] s0_s;
  logic         accept_s;
  logic         acc_s;
  logic         last_s;

  assign acc_s    = (state_q == ST_ACC);
  assign accept_s = (state_q == ST_WAIT_X) && !bus.start && bus.x_valid;

  goertzel_sample_counter #(
    .BLOCK_LEN (BLOCK_LEN),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.start),
    .inc  (acc_s && !bus.start),
    .last (last_s)
  );

  // mul_y is the product of coeff_q and s1_q issued when the sample was accepted
`ifdef GOERTZEL_SAT_EN
  assign s0_s = sat_add(x_q, bus.mul_y, s2_q);
`else
  assign s0_s = x_q + bus.mul_y - s2_q;
`endif

  assign bus.x_ready = (state_q == ST_WAIT_X) && !bus.start;
  assign bus.mul_en  = accept_s;
  assign bus.mul_a   = coeff_q;
  assign bus.mul_b   = s1_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.s1_out  = s1_out_q;
  assign bus.s2_out  = s2_out_q;

  always_comb begin
    state_d  = state_q;
    coeff_d  = coeff_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    x_d      = x_q;
    s1_out_d = s1_out_q;
    s2_out_d = s2_out_q;
    done_d   = 1'b0;
    if (bus.start) begin
      coeff_d = bus.coeff;
      s1_d    = '0;
      s2_d    = '0;
      state_d = ST_WAIT_X;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT_X: begin
          if (accept_s) begin
            x_d     = bus.x_data;
            state_d = ST_ACC;
          end else begin
            state_d = ST_WAIT_X;
          end
        end
        ST_ACC: begin
          s2_d = s1_q;
          s1_d = s0_s;
          if (last_s) begin
            s1_out_d = s0_s;
            s2_out_d = s1_q;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_WAIT_X;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      coeff_q  <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      x_q      <= '0;
      s1_out_q <= '0;
      s2_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      coeff_q  <= coeff_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      x_q      <= x_d;
      s1_out_q <= s1_out_d;
      s2_out_q <= s2_out_d;
      done_q   <= done_d;
    end
  end

endmodule
